// File: rtl/up_counter.sv
// Programmable up counter with prescaler, wrap/saturate terminal handling,
// one-cycle terminal pulse, halted level and sticky overflow flag.
module up_counter #(
    parameter int WIDTH = 6,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             wrap,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             ovf
);

    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0]       state, state_n;
    logic [PS_W-1:0]  ps, ps_n;
    logic [WIDTH-1:0] count_n;
    logic             tc_n, ovf_n;
    logic             ps_last, at_term, step, rewrap, ps_adv;

    // The halted level is the FSM state itself.
    assign done = state[0];

    always_comb begin
        ps_last = (ps == PS_LAST);
        at_term = (count >= max_val);
        step    = en && ps_last && (state == RUN);
        // Raising wrap while halted restarts counting from a terminal step.
        rewrap  = en && ps_last && (state == HALT) && wrap;
        ps_adv  = en && ((state == RUN) || wrap);

        count_n = count;
        ps_n    = ps;
        tc_n    = 1'b0;
        ovf_n   = ovf;
        state_n = state;

        if (clr) begin
            count_n = '0;
            ps_n    = '0;
            ovf_n   = 1'b0;
            state_n = RUN;
        end else if (load) begin
            count_n = load_val;
            ps_n    = '0;
            state_n = RUN;
        end else begin
            if (ps_adv) begin
                ps_n = ps_last ? '0 : ps + 1'b1;
            end
            case (state)
                RUN: begin
                    if (step) begin
                        if (!at_term) begin
                            count_n = count + 1'b1;
                        end else if (wrap) begin
                            count_n = '0;
                            ovf_n   = 1'b1;
                            tc_n    = 1'b1;
                        end else begin
                            count_n = max_val;
                            tc_n    = 1'b1;
                            state_n = HALT;
                        end
                    end
                end
                HALT: begin
                    if (rewrap) begin
                        count_n = '0;
                        ovf_n   = 1'b1;
                        tc_n    = 1'b1;
                        state_n = RUN;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ps    <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            state <= RUN;
        end else begin
            count <= count_n;
            ps    <= ps_n;
            tc    <= tc_n;
            ovf   <= ovf_n;
            state <= state_n;
        end
    end

endmodule

// File: tb/tb_up_counter.sv
// Directed bench for up_counter: a DIV=1 and a DIV=4 instance share inputs;
// vector tables plus hand-written reset, wrap-run and prescaler sequences.
module tb_up_counter;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, clr, load, wrap;
    logic [W-1:0] load_val, max_val;
    logic [W-1:0] count1, count4;
    logic         tc1, done1, ovf1, tc4, done4, ovf4;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         clr, load, en, wrap;
        logic [W-1:0] load_val, max_val;
        logic [W-1:0] exp_count;
        logic         exp_tc, exp_done, exp_ovf;
    } vec_t;

    vec_t tab1[$];
    vec_t tab4[$];

    up_counter #(.WIDTH(W), .DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .max_val(max_val), .wrap(wrap),
        .count(count1), .tc(tc1), .done(done1), .ovf(ovf1)
    );

    up_counter #(.WIDTH(W), .DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .max_val(max_val), .wrap(wrap),
        .count(count4), .tc(tc4), .done(done4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic c, l, e, wr, input int lv, mv, ec,
                                input logic et, ed, eo);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.wrap = wr;
        v.load_val = W'(lv); v.max_val = W'(mv);
        v.exp_count = W'(ec); v.exp_tc = et; v.exp_done = ed; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, l, e, wr, input logic [W-1:0] lv, mv);
        clr = c; load = l; en = e; wrap = wr; load_val = lv; max_val = mv;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v.clr, v.load, v.en, v.wrap, v.load_val, v.max_val);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Saturate, reload, wrap-raise exit, out-of-range, max_val change, priority, max_val=0
        tab1.push_back(mk(1,0,0,0, 0, 5,  0,0,0,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  1,0,0,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  2,0,0,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  3,0,0,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  4,0,0,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  5,0,0,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  5,1,1,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  5,0,1,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  5,0,1,0));
        tab1.push_back(mk(0,1,1,0, 2, 5,  2,0,0,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  3,0,0,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  4,0,0,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  5,0,0,0));
        tab1.push_back(mk(0,0,1,0, 0, 5,  5,1,1,0));
        tab1.push_back(mk(0,0,1,1, 0, 5,  0,1,0,1));
        tab1.push_back(mk(0,0,1,1, 0, 5,  1,0,0,1));
        tab1.push_back(mk(1,0,0,1, 0, 5,  0,0,0,0));
        tab1.push_back(mk(0,1,0,1, 40,10, 40,0,0,0));
        tab1.push_back(mk(0,0,1,1, 0, 10, 0,1,0,1));
        tab1.push_back(mk(0,1,0,0, 7, 20, 7,0,0,1));
        tab1.push_back(mk(0,0,1,0, 0, 3,  3,1,1,1));
        tab1.push_back(mk(0,0,1,0, 0, 3,  3,0,1,1));
        tab1.push_back(mk(1,1,1,0, 17,3,  0,0,0,0));
        tab1.push_back(mk(0,1,0,0, 17,3,  17,0,0,0));
        tab1.push_back(mk(0,0,1,1, 0, 0,  0,1,0,1));
        tab1.push_back(mk(0,0,1,1, 0, 0,  0,1,0,1));
        tab1.push_back(mk(0,0,0,1, 0, 0,  0,0,0,1));
        tab1.push_back(mk(0,1,0,1, 22,63, 22,0,0,1));
        tab1.push_back(mk(0,0,1,1, 0, 63, 23,0,0,1));

        // DIV=4 prescaler: en 1,0,1,1,1 then a load restarts the wait
        tab4.push_back(mk(1,0,0,1, 0, 63, 0,0,0,0));
        tab4.push_back(mk(0,0,1,1, 0, 63, 0,0,0,0));
        tab4.push_back(mk(0,0,0,1, 0, 63, 0,0,0,0));
        tab4.push_back(mk(0,0,1,1, 0, 63, 0,0,0,0));
        tab4.push_back(mk(0,0,1,1, 0, 63, 0,0,0,0));
        tab4.push_back(mk(0,0,1,1, 0, 63, 1,0,0,0));
        tab4.push_back(mk(0,0,1,1, 0, 63, 1,0,0,0));
        tab4.push_back(mk(0,0,1,1, 0, 63, 1,0,0,0));
        tab4.push_back(mk(0,1,1,1, 10,63, 10,0,0,0));
        tab4.push_back(mk(0,0,1,1, 0, 63, 10,0,0,0));
        tab4.push_back(mk(0,0,1,1, 0, 63, 10,0,0,0));
        tab4.push_back(mk(0,0,1,1, 0, 63, 10,0,0,0));
        tab4.push_back(mk(0,0,1,1, 0, 63, 11,0,0,0));

        // Reset
        rst_n = 1'b0;
        drive(0, 0, 0, 0, '0, '0);
        #12;
        check("reset.count1", count1, 0);
        check("reset.tc1",    tc1,    0);
        check("reset.done1",  done1,  0);
        check("reset.ovf1",   ovf1,   0);
        check("reset.count4", count4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap run: max_val=9 for 25 enabled cycles
        apply(mk(1,0,0,1, 0, 9, 0,0,0,0));
        for (int k = 1; k <= 25; k++) exp_q.push_back(W'(k % 10));
        @(negedge clk);
        drive(0, 0, 1, 1, '0, 6'd9);
        for (int k = 1; k <= 25; k++) begin
            logic [W-1:0] e;
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("wrap_run[%0d].count", k), count1, e);
            check($sformatf("wrap_run[%0d].tc", k), tc1, (k % 10) == 0);
            check($sformatf("wrap_run[%0d].ovf", k), ovf1, k >= 10);
        end

        for (int i = 0; i < tab1.size(); i++) begin
            apply(tab1[i]);
            check($sformatf("tab1[%0d].count", i), count1, tab1[i].exp_count);
            check($sformatf("tab1[%0d].tc", i),    tc1,    tab1[i].exp_tc);
            check($sformatf("tab1[%0d].done", i),  done1,  tab1[i].exp_done);
            check($sformatf("tab1[%0d].ovf", i),   ovf1,   tab1[i].exp_ovf);
        end

        // Reset pulse between edges with count=23, ovf=1
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset.count", count1, 0);
        check("midreset.tc",    tc1,    0);
        check("midreset.done",  done1,  0);
        check("midreset.ovf",   ovf1,   0);
        #1 rst_n = 1'b1;
        drive(0, 0, 1, 1, '0, 6'd63);
        @(posedge clk);
        #1;
        check("post_reset.count", count1, 1);

        for (int i = 0; i < tab4.size(); i++) begin
            apply(tab4[i]);
            check($sformatf("tab4[%0d].count", i), count4, tab4[i].exp_count);
            check($sformatf("tab4[%0d].tc", i),    tc4,    tab4[i].exp_tc);
            check($sformatf("tab4[%0d].done", i),  done4,  tab4[i].exp_done);
            check($sformatf("tab4[%0d].ovf", i),   ovf4,   tab4[i].exp_ovf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
